// File: rtl/psum_ofifo.sv
// psum_ofifo: per-lane psum output FIFOs that are popped as one full row.
// Define PSUM_OFIFO_OVERFLOW_FLAG_EN to add the sticky o_overflow port.
module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
`ifdef PSUM_OFIFO_OVERFLOW_FLAG_EN
    output logic                   o_overflow,
`endif
    output logic                   o_ready
);
    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);
    localparam logic [cw-1:0] full_cnt = cw'(depth);

    logic [col-1:0] w_full;
    logic [col-1:0] w_empty;
    logic [col-1:0] w_wen;
    logic           w_pop;

    assign o_valid = &(~w_empty);
    assign o_full  = |w_full;
    assign o_ready = !o_full;
    assign w_pop   = rd && o_valid;

    genvar i;
    generate
        for (i = 0; i < col; i++) begin : g_lane
            logic [psum_bw-1:0] r_mem [depth];
            logic [aw-1:0]      r_wptr;
            logic [aw-1:0]      r_rptr;
            logic [cw-1:0]      r_cnt;
            logic [psum_bw-1:0] r_out;

            assign w_full[i]  = r_cnt == full_cnt;
            assign w_empty[i] = r_cnt == '0;
            // A pop in the same cycle frees a slot, so a full lane may still accept.
            assign w_wen[i]   = wr[i] && (!w_full[i] || w_pop);
            assign out[i*psum_bw +: psum_bw] = r_out;

            always_ff @(posedge clk) begin
                if (!reset && w_wen[i])
                    r_mem[r_wptr] <= in[i*psum_bw +: psum_bw];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                    r_out  <= '0;
                end else begin
                    if (w_wen[i])
                        r_wptr <= r_wptr + aw'(1);
                    if (w_pop) begin
                        r_rptr <= r_rptr + aw'(1);
                        r_out  <= r_mem[r_rptr];
                    end
                    r_cnt <= r_cnt + cw'(w_wen[i]) - cw'(w_pop);
                end
            end
        end
    endgenerate

`ifdef PSUM_OFIFO_OVERFLOW_FLAG_EN
    logic r_overflow;
    logic w_drop;

    assign w_drop     = |(wr & w_full) && !w_pop;
    assign o_overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (reset)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
    end
`endif
endmodule
